// File: rtl/wb_cmd_master.sv
// Wishbone classic master that executes queued commands one at a time. Each
// command gets a bounded wait for ack_i and produces exactly one response.
module wb_cmd_master #(
    parameter int DATA_W     = 32,
    parameter int ADR_W      = 16,
    parameter int ALIGN_FULL = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_we_i,
    input  logic [ADR_W-1:0]            cmd_adr_i,
    input  logic [DATA_W-1:0]           cmd_dat_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [DATA_W-1:0]           rsp_dat_o,
    output logic                        rsp_we_o,
    output logic                        rsp_err_o,
    output logic [ADR_W-1:0]            adr_o,
    output logic [DATA_W-1:0]           dat_o,
    input  logic [DATA_W-1:0]           dat_i,
    output logic                        we_o,
    output logic [DATA_W/8-1:0]         sel_o,
    output logic                        stb_o,
    output logic                        cyc_o,
    input  logic                        ack_i,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);
    localparam int SEL_W  = DATA_W / 8;
    localparam int LANE_W = $clog2(SEL_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TMO_W  = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               fifo_we  [FIFO_DEPTH];
    logic [ADR_W-1:0]   fifo_adr [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_dat [FIFO_DEPTH];
    logic               head_we;
    logic [ADR_W-1:0]   head_adr;
    logic [DATA_W-1:0]  head_dat;
    logic               push, pop;

    function automatic logic [SEL_W-1:0] lane_sel(input logic [LANE_W-1:0] lane);
        if (ALIGN_FULL != 0) return '1;
        return SEL_W'(1) << lane;
    endfunction

    function automatic logic [DATA_W-1:0] wr_steer(input logic [DATA_W-1:0] dat,
                                                   input logic [LANE_W-1:0] lane);
        if (ALIGN_FULL != 0) return dat;
        return DATA_W'(dat[7:0]) << {lane, 3'b000};
    endfunction

    function automatic logic [DATA_W-1:0] rd_lane(input logic [DATA_W-1:0] dat,
                                                  input logic [LANE_W-1:0] lane);
        if (ALIGN_FULL != 0) return dat;
        return (dat >> {lane, 3'b000}) & DATA_W'(8'hFF);
    endfunction

    assign cmd_ready_o = (level_o < LVL_W'(FIFO_DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    // Pop decision uses the registered level, so a fresh push waits one edge.
    assign pop         = (state == IDLE) && (level_o != '0);
    assign busy_o      = (state != IDLE) || (level_o != '0);
    assign head_we     = fifo_we[rd_ptr];
    assign head_adr    = fifo_adr[rd_ptr];
    assign head_dat    = fifo_dat[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_we[wr_ptr]  <= cmd_we_i;
            fifo_adr[wr_ptr] <= cmd_adr_i;
            fifo_dat[wr_ptr] <= cmd_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level_o <= level_o + LVL_W'(1);
            else if (pop && !push) level_o <= level_o - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            adr_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_we_o    <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        adr_o   <= head_adr;
                        we_o    <= head_we;
                        sel_o   <= lane_sel(head_adr[LANE_W-1:0]);
                        dat_o   <= head_we ? wr_steer(head_dat, head_adr[LANE_W-1:0]) : '0;
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    // An ack arriving on the last counted cycle still wins.
                    if (ack_i || (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
                        rsp_err_o   <= !ack_i;
                        rsp_dat_o   <= (ack_i && !we_o) ? rd_lane(dat_i, adr_o[LANE_W-1:0]) : '0;
                        rsp_we_o    <= we_o;
                        rsp_valid_o <= 1'b1;
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        we_o        <= 1'b0;
                        sel_o       <= '0;
                        adr_o       <= '0;
                        dat_o       <= '0;
                        state       <= RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: a byte-lane and a full-word instance share all
// inputs and are checked in lockstep against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_cmd_master;
    localparam int DW = 32, AW = 16, DEPTH = 4, TMO = 8, NRAND = 40;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } cmd_t;

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_we, rsp_ready, ack;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat, wb_dat;

    logic cmd_ready_b, rsp_valid_b, rsp_we_b, rsp_err_b, we_b, stb_b, cyc_b, busy_b;
    logic cmd_ready_f, rsp_valid_f, rsp_we_f, rsp_err_f, we_f, stb_f, cyc_f, busy_f;
    logic [DW-1:0] rsp_dat_b, dat_o_b, rsp_dat_f, dat_o_f;
    logic [AW-1:0] adr_b, adr_f;
    logic [3:0]    sel_b, sel_f;
    logic [2:0]    level_b, level_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.DATA_W(DW), .ADR_W(AW), .ALIGN_FULL(0), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut_b (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_b),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_b),
        .rsp_we_o(rsp_we_b), .rsp_err_o(rsp_err_b), .adr_o(adr_b), .dat_o(dat_o_b),
        .dat_i(wb_dat), .we_o(we_b), .sel_o(sel_b), .stb_o(stb_b), .cyc_o(cyc_b),
        .ack_i(ack), .busy_o(busy_b), .level_o(level_b));

    wb_cmd_master #(.DATA_W(DW), .ADR_W(AW), .ALIGN_FULL(1), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut_f (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_f),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid_f), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_f),
        .rsp_we_o(rsp_we_f), .rsp_err_o(rsp_err_f), .adr_o(adr_f), .dat_o(dat_o_f),
        .dat_i(wb_dat), .we_o(we_f), .sel_o(sel_f), .stb_o(stb_f), .cyc_o(cyc_f),
        .ack_i(ack), .busy_o(busy_f), .level_o(level_f));

    // All tasks begin and end just after a falling edge; inputs change there.
    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; ack = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] obs, exp;
        rst = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 16'h1234; cmd_dat = 32'hA5A5A5A5;
        ack = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        exp = 128'h1;
        obs = {cyc_b, stb_b, we_b, sel_b, adr_b, dat_o_b, rsp_valid_b, rsp_dat_b, rsp_we_b, rsp_err_b, busy_b, level_b, cmd_ready_b};
        checks++; if (obs !== exp) begin errors++; $display("FAIL reset_byte: got %h want %h", obs, exp); end
        obs = {cyc_f, stb_f, we_f, sel_f, adr_f, dat_o_f, rsp_valid_f, rsp_dat_f, rsp_we_f, rsp_err_f, busy_f, level_f, cmd_ready_f};
        checks++; if (obs !== exp) begin errors++; $display("FAIL reset_full: got %h want %h", obs, exp); end
        @(negedge clk);
        obs = {level_b, level_f, busy_b, busy_f, cyc_b};
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL reset_drop_cmd: got %h want %h", obs, exp); end
    endtask

    task automatic test_full_write();
        logic [127:0] obs, exp;
        do_reset();
        push_cmd(1'b1, 16'h0004, 32'hDEADBEEF);
        @(negedge clk);
        obs = {cyc_f, stb_f, we_f, sel_f, adr_f, dat_o_f};
        exp = {1'b1, 1'b1, 1'b1, 4'hF, 16'h0004, 32'hDEADBEEF};
        checks++; if (obs !== exp) begin errors++; $display("FAIL full_write_bus: got %h want %h", obs, exp); end
        obs = {cyc_b, stb_b, we_b, sel_b, adr_b, dat_o_b};
        exp = {1'b1, 1'b1, 1'b1, 4'b0001, 16'h0004, 32'h000000EF};
        checks++; if (obs !== exp) begin errors++; $display("FAIL byte_write_bus: got %h want %h", obs, exp); end
        @(negedge clk);
        obs = {cyc_b, cyc_f, rsp_valid_b, rsp_valid_f};
        exp = 128'hC;
        checks++; if (obs !== exp) begin errors++; $display("FAIL write_wait_ack: got %h want %h", obs, exp); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        obs = {rsp_valid_f, rsp_err_f, rsp_we_f, rsp_dat_f, cyc_f, stb_f, we_f, sel_f, adr_f, dat_o_f,
               rsp_valid_b, rsp_err_b, rsp_we_b, rsp_dat_b, cyc_b, sel_b, adr_b, dat_o_b};
        exp = {1'b1, 1'b0, 1'b1, 32'h0, 3'b000, 4'h0, 16'h0, 32'h0,
               1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0};
        checks++; if (obs !== exp) begin errors++; $display("FAIL write_rsp: got %h want %h", obs, exp); end
        @(negedge clk);
        obs = {rsp_valid_b, rsp_valid_f, rsp_we_b, rsp_we_f, busy_b, busy_f};
        exp = 128'h3F;
        checks++; if (obs !== exp) begin errors++; $display("FAIL write_rsp_hold: got %h want %h", obs, exp); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        obs = {rsp_valid_b, rsp_valid_f, busy_b, busy_f};
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL write_rsp_release: got %h want %h", obs, exp); end
    endtask

    task automatic test_byte_read();
        logic [127:0] obs, exp;
        do_reset();
        push_cmd(1'b0, 16'h0003, 32'hCAFEF00D);
        @(negedge clk);
        obs = {cyc_b, we_b, sel_b, adr_b, dat_o_b, cyc_f, we_f, sel_f, adr_f, dat_o_f};
        exp = {1'b1, 1'b0, 4'b1000, 16'h0003, 32'h0, 1'b1, 1'b0, 4'hF, 16'h0003, 32'h0};
        checks++; if (obs !== exp) begin errors++; $display("FAIL read_bus: got %h want %h", obs, exp); end
        ack = 1'b1; wb_dat = 32'h11223344;
        @(negedge clk);
        ack = 1'b0;
        obs = {rsp_valid_b, rsp_err_b, rsp_we_b, rsp_dat_b, rsp_valid_f, rsp_err_f, rsp_we_f, rsp_dat_f};
        exp = {3'b100, 32'h00000011, 3'b100, 32'h11223344};
        checks++; if (obs !== exp) begin errors++; $display("FAIL read_rsp: got %h want %h", obs, exp); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic [127:0] obs, exp;
        logic [DW-1:0] b_dat;
        int n;
        do_reset();
        push_cmd(1'b0, 16'h0010, $urandom);
        b_dat = $urandom;
        push_cmd(1'b1, 16'h0021, b_dat);
        n = 0;
        while (cyc_b && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != TMO) begin errors++; $display("FAIL timeout_cyc_len: got %0d cycles want %0d", n, TMO); end
        obs = {cyc_b, cyc_f, rsp_valid_b, rsp_err_b, rsp_we_b, rsp_dat_b, rsp_valid_f, rsp_err_f, rsp_we_f, rsp_dat_f, level_b};
        exp = {2'b00, 3'b110, 32'h0, 3'b110, 32'h0, 3'd1};
        checks++; if (obs !== exp) begin errors++; $display("FAIL timeout_rsp: got %h want %h", obs, exp); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        obs = {cyc_b, cyc_f, rsp_valid_b};
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL timeout_no_early_pop: got %h want %h", obs, exp); end
        @(negedge clk);
        obs = {cyc_b, we_b, sel_b, adr_b, dat_o_b, cyc_f, sel_f, dat_o_f};
        exp = {1'b1, 1'b1, 4'b0010, 16'h0021, 16'h0, b_dat[7:0], 8'h0, 1'b1, 4'hF, b_dat};
        checks++; if (obs !== exp) begin errors++; $display("FAIL after_timeout_bus: got %h want %h", obs, exp); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        obs = {rsp_valid_b, rsp_err_b, rsp_we_b, rsp_dat_b, rsp_valid_f, rsp_err_f, rsp_we_f, rsp_dat_f};
        exp = {3'b101, 32'h0, 3'b101, 32'h0};
        checks++; if (obs !== exp) begin errors++; $display("FAIL after_timeout_rsp: got %h want %h", obs, exp); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] obs, exp;
        cmd_t bp[$];
        cmd_t c;
        logic [DW-1:0] d, eb, ef;
        int got;
        do_reset();
        d = $urandom; wb_dat = d; ack = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c.we = 1'($urandom_range(0, 1)); c.adr = 16'($urandom); c.dat = $urandom;
            bp.push_back(c);
            push_cmd(c.we, c.adr, c.dat);
        end
        obs = {level_b, cmd_ready_b, level_f, cmd_ready_f, busy_b};
        exp = {3'd4, 1'b0, 3'd4, 1'b0, 1'b1};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bp_full: got %h want %h", obs, exp); end
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        obs = {level_b, level_f};
        exp = {3'd4, 3'd4};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bp_push_while_full: got %h want %h", obs, exp); end
        rsp_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 60 && got < 6; t++) begin
            if (rsp_valid_b || rsp_valid_f) begin
                if (bp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bp_extra_rsp: got an unexpected response want none");
                end else begin
                    c = bp.pop_front();
                    eb = c.we ? 32'h0 : ((d >> (8 * c.adr[1:0])) & 32'hFF);
                    ef = c.we ? 32'h0 : d;
                    obs = {rsp_valid_b, rsp_we_b, rsp_err_b, rsp_dat_b, rsp_valid_f, rsp_we_f, rsp_err_f, rsp_dat_f};
                    exp = {1'b1, c.we, 1'b0, eb, 1'b1, c.we, 1'b0, ef};
                    checks++; if (obs !== exp) begin errors++; $display("FAIL bp_rsp_%0d: got %h want %h", got, obs, exp); end
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 5) begin errors++; $display("FAIL bp_rsp_count: got %0d want 5", got); end
        obs = {level_b, busy_b, level_f, busy_f};
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL bp_drained: got %h want %h", obs, exp); end
        ack = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        logic [127:0] obs, exp;
        int pulses;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(1'($urandom_range(0, 1)), 16'($urandom), $urandom);
        obs = {cyc_b, level_b, cyc_f, level_f};
        exp = {1'b1, 3'd3, 1'b1, 3'd3};
        checks++; if (obs !== exp) begin errors++; $display("FAIL midbus_pre: got %h want %h", obs, exp); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs = {cyc_b, stb_b, level_b, busy_b, rsp_valid_b, adr_b, cyc_f, stb_f, level_f, busy_f, rsp_valid_f};
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL midbus_reset: got %h want %h", obs, exp); end
        ack = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid_b || rsp_valid_f || cyc_b || cyc_f) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midbus_quiet: got %0d active cycles want 0", pulses); end
        ack = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] obs, exp;
        cmd_t q[$];
        cmd_t cur, nxt;
        bit inflight = 0, in_bus = 0, done_pend = 0, hs_pend = 0, push_pend = 0, exp_err = 0, exp_pop;
        int bus_k = 0, delay = 0, sent = 0, got = 0;
        logic [DW-1:0] ack_dat, exp_b, exp_f;
        logic [1:0] ln;
        cur = '0; nxt = '0; ack_dat = '0; exp_b = '0; exp_f = '0;
        do_reset();
        for (int t = 0; t < 4000 && got < NRAND; t++) begin
            cmd_valid = (sent < NRAND) && ($urandom_range(0, 1) == 1);
            cmd_we = 1'($urandom_range(0, 1)); cmd_adr = 16'($urandom); cmd_dat = $urandom;
            push_pend = cmd_valid && (q.size() < DEPTH);
            if (push_pend) begin
                nxt.we = cmd_we; nxt.adr = cmd_adr; nxt.dat = cmd_dat;
                sent++;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            hs_pend = inflight && !in_bus && rsp_ready;
            ack = 1'b0; wb_dat = $urandom; done_pend = 0;
            if (in_bus) begin
                if (bus_k == delay) begin
                    ack = 1'b1; ack_dat = wb_dat; done_pend = 1; exp_err = 0;
                end else if (bus_k == TMO - 1) begin
                    done_pend = 1; exp_err = 1;
                end
                bus_k++;
                if (done_pend) begin
                    ln = cur.adr[1:0];
                    exp_b = (exp_err || cur.we) ? 32'h0 : ((ack_dat >> (8 * ln)) & 32'hFF);
                    exp_f = (exp_err || cur.we) ? 32'h0 : ack_dat;
                end
            end
            @(negedge clk);
            exp_pop = !inflight && (q.size() > 0);
            if (hs_pend) begin
                inflight = 0;
                got++;
            end
            if (done_pend) in_bus = 0;
            if (exp_pop) begin
                cur = q.pop_front();
                in_bus = 1; inflight = 1; bus_k = 0;
                delay = int'($urandom_range(0, TMO + 1));
            end
            if (push_pend) q.push_back(nxt);
            obs = {cyc_b, stb_b, cyc_f, stb_f, rsp_valid_b, rsp_valid_f, busy_b, busy_f,
                   level_b, level_f, cmd_ready_b, cmd_ready_f};
            exp = {{4{in_bus}}, {2{inflight && !in_bus}}, {2{inflight || (q.size() > 0)}},
                   3'(q.size()), 3'(q.size()), {2{q.size() < DEPTH}}};
            checks++; if (obs !== exp) begin errors++; $display("FAIL rand_ctrl t=%0d: got %h want %h", t, obs, exp); end
            ln = cur.adr[1:0];
            obs = {we_b, sel_b, adr_b, dat_o_b, we_f, sel_f, adr_f, dat_o_f};
            if (in_bus)
                exp = {cur.we, 4'b0001 << ln, cur.adr, cur.we ? ({24'h0, cur.dat[7:0]} << (8 * ln)) : 32'h0,
                       cur.we, 4'hF, cur.adr, cur.we ? cur.dat : 32'h0};
            else
                exp = '0;
            checks++; if (obs !== exp) begin errors++; $display("FAIL rand_bus t=%0d: got %h want %h", t, obs, exp); end
            if (inflight && !in_bus) begin
                obs = {rsp_we_b, rsp_err_b, rsp_dat_b, rsp_we_f, rsp_err_f, rsp_dat_f};
                exp = {cur.we, exp_err, exp_b, cur.we, exp_err, exp_f};
                checks++; if (obs !== exp) begin errors++; $display("FAIL rand_rsp t=%0d: got %h want %h", t, obs, exp); end
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0; ack = 1'b0;
        checks++; if (got != NRAND) begin errors++; $display("FAIL rand_count: got %0d responses want %0d", got, NRAND); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; ack = 1'b0; wb_dat = '0;
        @(negedge clk);
        test_reset();
        test_full_write();
        test_byte_read();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1);
    end
endmodule
